// File: rtl/tran_4x4_pipe.sv
// tran_4x4_pipe: forward 4x4 integer core transform Y = Cf*X*Cf^T (column pass, then row pass).
// Latency: 2 cycles from accept to out_valid; throughput is one block per cycle with no bubbles.
// Backpressure: stage 1 advances when stage 2 is empty or draining; in_ready is combinational from that.
//
// Ports:
//   clk, reset (async, active-low)
//   in_valid/in_ready   : residual block handshake; residuals packed row-major, IN_WIDTH bits each
//   out_valid/out_ready : coefficient block handshake; transformed packed row-major, OUT_WIDTH bits each
//   out_blk_idx/out_last: block position within the macroblock (meaningful while out_valid)
// Optional macro TRAN_HADAMARD_EN adds input 'hadamard': that block uses the Hadamard rows in both
// passes and each output coefficient is (Y+1)>>>1 (luma DC path).
module tran_4x4_pipe #(
    parameter int IN_WIDTH    = 9,
    parameter int OUT_WIDTH   = IN_WIDTH + 6,
    parameter int BLKS_PER_MB = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [16*IN_WIDTH-1:0]        residuals,
`ifdef TRAN_HADAMARD_EN
    input  logic                          hadamard,
`endif
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [16*OUT_WIDTH-1:0]       transformed,
    output logic [$clog2(BLKS_PER_MB)-1:0] out_blk_idx,
    output logic                          out_last
);

    // Column sums of four residuals with weights up to 2 need 3 extra bits.
    localparam int T_W   = IN_WIDTH + 3;
    localparam int IDX_W = $clog2(BLKS_PER_MB);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLKS_PER_MB - 1);

    logic                        r_s1_vld;
    logic                        r_s2_vld;
    logic signed [T_W-1:0]       r_t [16];
    logic signed [OUT_WIDTH-1:0] r_y [16];
    logic [IDX_W-1:0]            r_idx;

    logic                        w_s1_adv;
    logic                        w_in_had;
    logic                        w_s1_had;
    logic signed [T_W-1:0]       w_x  [16];
    logic signed [T_W-1:0]       w_t  [16];
    logic signed [OUT_WIDTH-1:0] w_te [16];
    logic signed [OUT_WIDTH-1:0] w_yr [16];
    logic signed [OUT_WIDTH-1:0] w_y  [16];

`ifdef TRAN_HADAMARD_EN
    logic r_s1_had;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_had <= 1'b0;
        end else if (in_ready && in_valid) begin
            r_s1_had <= hadamard;
        end
    end

    assign w_in_had = hadamard;
    assign w_s1_had = r_s1_had;
`else
    assign w_in_had = 1'b0;
    assign w_s1_had = 1'b0;
`endif

    assign w_s1_adv = !r_s2_vld || out_ready;
    assign in_ready = !r_s1_vld || w_s1_adv;

    // Stage 1: column pass. Residuals are sign-extended first; doubling is done on the
    // operands so no partial sum is ever shifted.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            w_x[i] = T_W'($signed(residuals[i*IN_WIDTH +: IN_WIDTH]));
        end
    end

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            w_t[i] = '0;
        end
        for (int c = 0; c < 4; c++) begin
            w_t[c]   = w_x[c] + w_x[4+c] + w_x[8+c] + w_x[12+c];
            w_t[8+c] = w_x[c] - w_x[4+c] - w_x[8+c] + w_x[12+c];
            if (w_in_had) begin
                w_t[4+c]  = w_x[c] + w_x[4+c] - w_x[8+c] - w_x[12+c];
                w_t[12+c] = w_x[c] - w_x[4+c] + w_x[8+c] - w_x[12+c];
            end else begin
                w_t[4+c]  = (w_x[c] <<< 1) + w_x[4+c] - w_x[8+c] - (w_x[12+c] <<< 1);
                w_t[12+c] = w_x[c] - (w_x[4+c] <<< 1) + (w_x[8+c] <<< 1) - w_x[12+c];
            end
        end
    end

    // Stage 2: row pass on the registered column results, full output precision.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            w_te[i] = OUT_WIDTH'(r_t[i]);
        end
    end

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            w_yr[i] = '0;
            w_y[i]  = '0;
        end
        for (int r = 0; r < 4; r++) begin
            w_yr[r*4]   = w_te[r*4] + w_te[r*4+1] + w_te[r*4+2] + w_te[r*4+3];
            w_yr[r*4+2] = w_te[r*4] - w_te[r*4+1] - w_te[r*4+2] + w_te[r*4+3];
            if (w_s1_had) begin
                w_yr[r*4+1] = w_te[r*4] + w_te[r*4+1] - w_te[r*4+2] - w_te[r*4+3];
                w_yr[r*4+3] = w_te[r*4] - w_te[r*4+1] + w_te[r*4+2] - w_te[r*4+3];
            end else begin
                w_yr[r*4+1] = (w_te[r*4] <<< 1) + w_te[r*4+1] - w_te[r*4+2] - (w_te[r*4+3] <<< 1);
                w_yr[r*4+3] = w_te[r*4] - (w_te[r*4+1] <<< 1) + (w_te[r*4+2] <<< 1) - w_te[r*4+3];
            end
        end
        for (int i = 0; i < 16; i++) begin
            // Hadamard output is halved with round-half-up; headroom makes the +1 safe.
            w_y[i] = w_s1_had ? ((w_yr[i] + OUT_WIDTH'(1)) >>> 1) : w_yr[i];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_vld <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                r_t[i] <= '0;
            end
        end else if (in_ready) begin
            r_s1_vld <= in_valid;
            if (in_valid) begin
                r_t <= w_t;
            end
        end
    end

    // Output register only reloads on advance, so data holds while stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s2_vld <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                r_y[i] <= '0;
            end
        end else if (w_s1_adv) begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_y <= w_y;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idx <= '0;
        end else if (r_s2_vld && out_ready) begin
            r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
        end
    end

    always_comb begin
        transformed = '0;
        for (int i = 0; i < 16; i++) begin
            transformed[i*OUT_WIDTH +: OUT_WIDTH] = r_y[i];
        end
    end

    assign out_valid   = r_s2_vld;
    assign out_blk_idx = r_idx;
    assign out_last    = (r_idx == LAST_IDX);

endmodule

// File: tb/tb_tran_4x4_pipe.sv
// tb_tran_4x4_pipe: directed bench for tran_4x4_pipe with hand-computed vectors and a reference model.
// Latency: checks the 2-cycle accept-to-output timing and streaming throughput.
// Backpressure: stalls out_ready mid-stream and checks hold/ordering and in_ready.
module tb_tran_4x4_pipe;
    localparam int IW = 9;
    localparam int OW = 15;
    localparam int NB = 16;

    typedef int blk_t [16];

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [16*IW-1:0]   residuals = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [16*OW-1:0]   transformed;
    logic [3:0]         out_blk_idx;
    logic               out_last;
`ifdef TRAN_HADAMARD_EN
    logic               had_in = 1'b0;
`endif

    int errors = 0;
    int checks = 0;
    logic [16*IW-1:0] blkp [17];
    int cf [4][4] = '{'{1, 1, 1, 1}, '{2, 1, -1, -2}, '{1, -1, -1, 1}, '{1, -2, 2, -1}};

    tran_4x4_pipe #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .BLKS_PER_MB(NB)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .residuals  (residuals),
`ifdef TRAN_HADAMARD_EN
        .hadamard   (had_in),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .transformed(transformed),
        .out_blk_idx(out_blk_idx),
        .out_last   (out_last)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running want finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    function automatic longint coef(input int i);
        return longint'($signed(transformed[i*OW +: OW]));
    endfunction

    function automatic logic [16*IW-1:0] pack(input blk_t x);
        logic [16*IW-1:0] p;
        p = '0;
        for (int i = 0; i < 16; i++) p[i*IW +: IW] = IW'(x[i]);
        return p;
    endfunction

    // Reference: straight matrix products T = Cf*X, Y = T*Cf^T.
    function automatic void gold(input logic [16*IW-1:0] p, output blk_t y);
        int x [16];
        int t [16];
        for (int i = 0; i < 16; i++) x[i] = int'($signed(p[i*IW +: IW]));
        for (int i = 0; i < 4; i++)
            for (int c = 0; c < 4; c++) begin
                t[i*4+c] = 0;
                for (int k = 0; k < 4; k++) t[i*4+c] += cf[i][k] * x[k*4+c];
            end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                y[i*4+j] = 0;
                for (int k = 0; k < 4; k++) y[i*4+j] += t[i*4+k] * cf[j][k];
            end
    endfunction

    task automatic chk_blk(input string tag, input blk_t e);
        for (int i = 0; i < 16; i++) chk($sformatf("%s_y%0d", tag, i), coef(i), e[i]);
    endtask

    task automatic run_one(input string tag, input blk_t x, input blk_t e, input int eidx);
        @(negedge clk);
        residuals = pack(x);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        chk({tag, "_in_ready"}, in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_lat1_vld"}, out_valid, 0);
        @(negedge clk);
        chk({tag, "_lat2_vld"}, out_valid, 1);
        chk_blk(tag, e);
        chk({tag, "_idx"}, out_blk_idx, eidx);
        chk({tag, "_last"}, out_last, (eidx == NB - 1) ? 1 : 0);
        @(negedge clk);
        chk({tag, "_drained"}, out_valid, 0);
    endtask

    task automatic push_n(input int first, input int n);
        int w;
        for (int k = first; k < first + n; k++) begin
            @(negedge clk);
            residuals = blkp[k];
            in_valid  = 1'b1;
            w = 0;
            while (!in_ready && w < 100) begin
                @(negedge clk);
                w++;
            end
            if (w >= 100) chk("push_timeout", in_ready, 1);
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic collect_n(input int first, input int n, input int base);
        blk_t e;
        int w;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            w = 0;
            while (!(out_valid && out_ready) && w < 200) begin
                @(negedge clk);
                w++;
            end
            if (w >= 200) begin
                chk("collect_timeout", out_valid, 1);
                return;
            end
            gold(blkp[first+k], e);
            chk_blk($sformatf("blk%0d", first + k), e);
            chk($sformatf("blk%0d_idx", first + k), out_blk_idx, (base + k) % NB);
            chk($sformatf("blk%0d_last", first + k), out_last, ((base + k) % NB == NB - 1) ? 1 : 0);
        end
    endtask

    initial begin
        blk_t z, ones, neg, imp, e, e4;

        for (int i = 0; i < 16; i++) begin
            z[i] = 0; ones[i] = 1; neg[i] = -255; imp[i] = 0;
        end
        imp[0] = 1;

        // Reset state
        #3 reset = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_idx", out_blk_idx, 0);
        chk("rst_last", out_last, 0);
        chk_blk("rst", z);
        @(negedge clk);
        reset = 1'b1;

        // 1: zero block
        run_one("zero", z, z, 0);

        // 2: DC blocks
        e = z; e[0] = 16;
        run_one("ones", ones, e, 1);
        e = z; e[0] = -4080;
        run_one("neg255", neg, e, 2);

        // 3: impulse
        e = '{1, 2, 1, 1, 2, 4, 2, 2, 1, 2, 1, 1, 1, 2, 1, 1};
        run_one("impulse", imp, e, 3);

        // 4: five-block stream with a 3-cycle output stall
        for (int k = 0; k < 5; k++)
            for (int i = 0; i < 16; i++) e[i] = ((k * 71 + i * 13 + 3) % 511) - 255;
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 16; i++) e[i] = ((k * 71 + i * 13 + 3) % 511) - 255;
            blkp[k] = pack(e);
        end
        gold(blkp[1], e4);
        out_ready = 1'b1;
        fork
            push_n(0, 5);
            collect_n(0, 5, 4);
            begin
                int wc;
                wc = 0;
                @(negedge clk);
                while (!out_valid && wc < 100) begin
                    @(negedge clk);
                    wc++;
                end
                @(posedge clk);
                #2 out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_vld", out_valid, 1);
                    chk("stall_in_ready", in_ready, 0);
                    chk("stall_y0", coef(0), e4[0]);
                    chk("stall_y5", coef(5), e4[5]);
                    chk("stall_idx", out_blk_idx, 5);
                end
                @(posedge clk);
                #2 out_ready = 1'b1;
            end
        join

        // 5: full macroblock plus one, from a fresh reset
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("t5_rst_idx", out_blk_idx, 0);
        for (int k = 0; k < 17; k++) begin
            for (int i = 0; i < 16; i++) e[i] = ((k * 53 + i * 29 + 7) % 511) - 255;
            blkp[k] = pack(e);
        end
        fork
            push_n(0, 17);
            collect_n(0, 17, 0);
        join

        // 6: reset with two blocks in flight
        @(negedge clk);
        out_ready = 1'b0;
        push_n(0, 2);
        chk("t6_inflight_vld", out_valid, 1);
        chk("t6_inflight_idx", out_blk_idx, 1);
        #2 reset = 1'b0;
        #1;
        chk("t6_rst_vld", out_valid, 0);
        chk("t6_rst_idx", out_blk_idx, 0);
        chk("t6_rst_last", out_last, 0);
        chk("t6_rst_y0", coef(0), 0);
        chk("t6_rst_in_ready", in_ready, 1);
        @(negedge clk);
        reset = 1'b1;
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t6_no_ghost", out_valid, 0);
        end
        e = '{1, 2, 1, 1, 2, 4, 2, 2, 1, 2, 1, 1, 1, 2, 1, 1};
        run_one("t6_after", imp, e, 0);

`ifdef TRAN_HADAMARD_EN
        had_in = 1'b1;
        e = z; e[0] = 8;
        run_one("hadamard", ones, e, 1);
        had_in = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
